// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/response channel between the fetch
// controller (master) and the instruction memory (slave).
interface pc_fetch_ctrl_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program-counter and instruction-fetch controller. Keeps a single
// memory request in flight, presents each fetched instruction until the
// consumer accepts it, and handles traps, redirects and misaligned
// redirects. A flush flag marks a response that must be dropped because
// the PC changed while the request was already granted.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stall,
   input  logic                  redirect_valid,
   input  logic [31:0]           redirect_target,
   input  logic                  trap_valid,
   pc_fetch_ctrl_if.master       imem,
   output logic                  instr_valid,
   output logic [31:0]           instr,
   output logic [31:0]           instr_pc,
   output logic [31:0]           PC,
   output logic [31:0]           PCPlus4,
   output logic                  misalign_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      OUT  = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] instr_pc_q, instr_pc_d;
   logic        flush_q, flush_d;
   logic        misalign_q, misalign_d;
   logic        imem_req_q, imem_req_d;
   logic        instr_valid_q, instr_valid_d;

   logic        take_event;
   logic        misaligned;

   // A trap outranks a redirect; either is ignored while idle.
   assign take_event = (state_q != IDLE) && (trap_valid || redirect_valid);
   assign misaligned = !trap_valid && redirect_valid && (redirect_target[1:0] != 2'b00);

   assign imem.imem_req  = imem_req_q;
   assign imem.imem_addr = pc_q;
   assign instr_valid    = instr_valid_q;
   assign instr          = instr_q;
   assign instr_pc       = instr_pc_q;
   assign PC             = pc_q;
   assign PCPlus4        = pc_q + 32'd4;
   assign misalign_err   = misalign_q;

   // Next-state, next-PC and captured-instruction logic.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      flush_d    = flush_q;
      misalign_d = 1'b0;

      if (take_event) begin
         pc_d       = (trap_valid || misaligned) ? TRAP_VECTOR : redirect_target;
         misalign_d = misaligned;
         unique case (state_q)
            REQ: begin
               if (imem.imem_gnt) begin
                  state_d = WAIT;
                  flush_d = 1'b1;
               end else begin
                  state_d = REQ;
               end
            end
            WAIT: begin
               if (imem.imem_rvalid) begin
                  state_d = REQ;
                  flush_d = 1'b0;
               end else begin
                  flush_d = 1'b1;
               end
            end
            default: state_d = REQ;
         endcase
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) state_d = REQ;
            end
            REQ: begin
               if (imem.imem_gnt) state_d = WAIT;
            end
            WAIT: begin
               if (imem.imem_rvalid) begin
                  if (flush_q) begin
                     flush_d = 1'b0;
                     state_d = REQ;
                  end else begin
                     instr_d    = imem.imem_rdata;
                     instr_pc_d = pc_q;
                     state_d    = OUT;
                  end
               end
            end
            OUT: begin
               if (!stall) begin
                  pc_d    = pc_q + 32'd4;
                  state_d = REQ;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      imem_req_d    = (state_d == REQ);
      instr_valid_d = (state_d == OUT);
   end

   // State and output registers, cleared asynchronously while reset is low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= 32'h0;
         instr_pc_q    <= 32'h0;
         flush_q       <= 1'b0;
         misalign_q    <= 1'b0;
         imem_req_q    <= 1'b0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         flush_q       <= flush_d;
         misalign_q    <= misalign_d;
         imem_req_q    <= imem_req_d;
         instr_valid_q <= instr_valid_d;
      end
   end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0100, SHALL be the PC value loaded on trap or misaligned redirect.
REQ-003 The ports SHALL be as follows:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = in reset.
- start  in  1  level; leave IDLE and begin fetching.
- stall  in  1  consumer not accepting the instruction.
- redirect_valid  in  1  branch/jump taken.
- redirect_target  in  32  branch/jump destination.
- trap_valid  in  1  trap request.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address.
- imem_gnt  in  1  request accepted.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  response instruction.
- instr_valid  out  1  instr/instr_pc valid.
- instr  out  32  fetched instruction.
- instr_pc  out  32  address of instr.
- PC  out  32  current fetch PC.
- PCPlus4  out  32  PC + 4, combinational.
- misalign_err  out  1  one-cycle pulse on a misaligned redirect.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, REQ, WAIT and OUT; all other outputs SHALL be registered.
REQ-005 In IDLE: imem_req=0 and instr_valid=0; start=1 SHALL move to REQ on the next edge.
REQ-006 In REQ: imem_req=1 and imem_addr=PC.
- imem_addr SHALL change only on a redirect or trap.
- imem_gnt=1 SHALL move to WAIT.
REQ-007 In WAIT: imem_req=0; imem_rvalid=1 SHALL load instr<=imem_rdata and instr_pc<=PC, and move to OUT.
REQ-008 In OUT: instr_valid=1.
- stall=1: hold instr, instr_pc and PC; stay in OUT.
- stall=0: PC<=PC+4; move to REQ.
REQ-009 At most one request SHALL be outstanding, so fetch throughput is at most one instruction per 3 cycles.
REQ-010 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000 for both PC and PCPlus4.
REQ-011 Event priority, evaluated each edge in any non-IDLE state: trap_valid > redirect_valid > sequential/stall.
REQ-012 Trap: PC<=TRAP_VECTOR and instr_valid<=0.
REQ-013 Redirect with redirect_target[1:0]==0: PC<=redirect_target and instr_valid<=0.
REQ-014 Redirect with redirect_target[1:0]!=0: behave as a trap (PC<=TRAP_VECTOR) and pulse misalign_err for 1 cycle.
REQ-015 Next state after a redirect or trap:
- from OUT or REQ (no imem_gnt): REQ.
- from REQ with imem_gnt in the same cycle: WAIT, with the flush flag set.
- from WAIT: the flush flag SHALL be set and the state SHALL stay WAIT until imem_rvalid.
REQ-016 A response arriving while the flush flag is set SHALL be discarded: no instr_valid; the flag clears and the state moves to REQ.
REQ-017 A redirect in the same cycle as imem_rvalid in WAIT SHALL discard that response and move to REQ.
REQ-018 In IDLE, redirect_valid and trap_valid SHALL be ignored; start is ignored outside IDLE.
REQ-019 stall SHALL have no effect outside OUT.

Reset
REQ-020 While reset=0, the block SHALL asynchronously force:
- PC=RESET_PC and state=IDLE.
- imem_req=0, instr_valid=0, instr=0, instr_pc=0, misalign_err=0, flush flag=0.
REQ-021 Reset asserted mid-transaction SHALL abandon any outstanding request; a late imem_rvalid after reset SHALL be ignored.
REQ-022 Operation SHALL resume on the first rising clk edge after reset returns to 1.

Verification
REQ-023 Sequential fetch: reset release, start=1, imem_gnt and imem_rvalid one cycle after each request, stall=0 -> instr_pc sequence 0x0, 0x4, 0x8; instr_valid high one cycle in three.
REQ-024 Stall: hold stall=1 for 4 cycles in OUT with instr=0x00500093 -> instr, instr_pc and PC stable, no imem_req; stall=0 -> PC=0x4 and next request at 0x4.
REQ-025 Redirect in WAIT: redirect_target=0x200 -> in-flight response discarded, next imem_addr=0x200, next instr_pc=0x200.
REQ-026 Trap and misalignment:
- trap_valid with redirect_valid in the same cycle -> PC=0x100.
- redirect_target=0x202 -> PC=0x100 and a 1-cycle misalign_err.
REQ-027 Wrap: PC=0xFFFF_FFFC accepted with stall=0 -> PC=0x0 and PCPlus4=0x4.
REQ-028 Reset mid-WAIT: reset=0 -> outputs at reset values immediately; after release, an imem_rvalid pulse produces no instr_valid.
